// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared definitions for the display scheduler:
//   state_t        - scheduler FSM states (IDLE, SHOW)
//   NUM_REQ        - number of message requesters
//   BCD_W          - width of one 4-digit BCD message
//   cnt_width()    - bit width needed to count 0 .. n-1 (minimum 1 bit)
//   rr_pick()      - two-requester round-robin grant selection
// ---------------------------------------------------------------------------
package display_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned BCD_W   = 16;

    // Width of a counter whose values run 0 .. n-1; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Round-robin pick: a lone requester always wins, and when both ask,
    // the one that did not win last time gets the grant.
    function automatic logic rr_pick(input logic [NUM_REQ-1:0] valid,
                                     input logic               last);
        case (valid)
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            2'b11:   return ~last;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ---------------------------------------------------------------------------
// ms_tick_gen
// Free-running divider producing a one-cycle tick every CLK_DIV clocks.
// Ports:
//   i_clk   - system clock (rising edge)
//   i_reset - synchronous active-high reset, counter to 0
//   clear   - restart the count from 0 on the next edge
//   tick    - high while the counter sits at CLK_DIV-1
// ---------------------------------------------------------------------------
module ms_tick_gen #(
    parameter int unsigned CLK_DIV = 100000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic clear,
    output logic tick
);
    import display_pkg::*;

    localparam int unsigned      CNT_W = cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    // The counter wraps on the tick cycle itself, so it never exceeds LAST.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// ---------------------------------------------------------------------------
// display_scheduler
// Shares one 4-digit seven-segment display between two message requesters.
// A round-robin arbiter accepts one message at a time; the accepted message
// is held on the display for DWELL_MS milliseconds (CLK_DIV clocks per ms).
// Ports:
//   i_clk        - system clock (rising edge)
//   i_reset      - synchronous active-high reset
//   i_req_valid  - per-requester message valid
//   i_req_bcd    - per-requester BCD message, requester n at [16n+15:16n]
//   o_req_ready  - per-requester accept strobe (combinational, IDLE only)
//   o_bcd        - BCD word for the seven-segment driver
//   o_owner      - one-hot owner of the displayed message during a dwell
//   o_busy       - high while a dwell is in progress
// ---------------------------------------------------------------------------
module display_scheduler
    import display_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 100000,
    parameter int unsigned DWELL_MS = 2000
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ*BCD_W-1:0] i_req_bcd,
    output logic [NUM_REQ-1:0]       o_req_ready,
    output logic [BCD_W-1:0]         o_bcd,
    output logic [NUM_REQ-1:0]       o_owner,
    output logic                     o_busy
);

    localparam int unsigned        DWELL_W    = cnt_width(DWELL_MS);
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_MS - 1);

    state_t               state_q, state_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [BCD_W-1:0]     bcd_q,   bcd_d;
    logic [NUM_REQ-1:0]   owner_q, owner_d;
    logic                 last_q,  last_d;

    logic                 grant;
    logic [NUM_REQ-1:0]   grant_oh;
    logic                 xfer;
    logic                 ms_tick;

    ms_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .clear   (xfer),
        .tick    (ms_tick)
    );

    // Arbiter: grant is offered only in IDLE and never while reset is high,
    // so a reset arriving together with a request cannot complete a transfer.
    always_comb begin
        grant              = rr_pick(i_req_valid, last_q);
        grant_oh           = '0;
        grant_oh[grant]    = 1'b1;
        o_req_ready        = '0;
        if ((state_q == IDLE) && !i_reset && (|i_req_valid)) begin
            o_req_ready = grant_oh;
        end
    end

    assign xfer = |(i_req_valid & o_req_ready);

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        bcd_d   = bcd_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = SHOW;
                    dwell_d = DWELL_LOAD;
                    bcd_d   = grant ? i_req_bcd[2*BCD_W-1:BCD_W]
                                    : i_req_bcd[BCD_W-1:0];
                    owner_d = grant_oh;
                    last_d  = grant;
                end
            end
            SHOW: begin
                // The dwell counter is loaded with DWELL_MS-1, so the tick
                // that finds it at zero is the DWELL_MS-th tick of the dwell.
                if (ms_tick) begin
                    if (dwell_q == '0) begin
                        state_d = IDLE;
                        owner_d = '0;
                    end else begin
                        dwell_d = dwell_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            dwell_q <= '0;
            bcd_q   <= '0;
            owner_q <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            bcd_q   <= bcd_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // The displayed word goes straight to the segment driver; it keeps the
    // last message after the dwell ends.
    assign o_bcd   = bcd_q;
    assign o_owner = owner_q;
    assign o_busy  = (state_q == SHOW);

endmodule

// File: tb/tb_display_scheduler.sv
module tb_display_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: CLK_DIV=4, DWELL_MS=3 -> 12-cycle dwell
    logic        rst;
    logic [1:0]  vld;
    logic [31:0] bcd_in;
    logic [1:0]  rdy;
    logic [15:0] obcd;
    logic [1:0]  own;
    logic        busy;

    display_scheduler #(.CLK_DIV(4), .DWELL_MS(3)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req_valid (vld),
        .i_req_bcd   (bcd_in),
        .o_req_ready (rdy),
        .o_bcd       (obcd),
        .o_owner     (own),
        .o_busy      (busy)
    );

    // Second DUT: CLK_DIV=1, DWELL_MS=1 -> 1-cycle dwell
    logic        rst1;
    logic [1:0]  vld1;
    logic [31:0] bcd_in1;
    logic [1:0]  rdy1;
    logic [15:0] obcd1;
    logic [1:0]  own1;
    logic        busy1;

    display_scheduler #(.CLK_DIV(1), .DWELL_MS(1)) dut1 (
        .i_clk       (clk),
        .i_reset     (rst1),
        .i_req_valid (vld1),
        .i_req_bcd   (bcd_in1),
        .o_req_ready (rdy1),
        .o_bcd       (obcd1),
        .o_owner     (own1),
        .o_busy      (busy1)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  vld;
        logic [15:0] b0;
        logic [15:0] b1;
        logic [1:0]  rdy;
        logic [15:0] bcd;
        logic [1:0]  own;
        logic        busy;
    } vec_t;

    vec_t tbl[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic r, input logic [1:0] v,
                                input logic [15:0] b0, input logic [15:0] b1,
                                input logic [1:0] er, input logic [15:0] eb,
                                input logic [1:0] eo, input logic ebusy);
        vec_t t;
        t.rst = r; t.vld = v; t.b0 = b0; t.b1 = b1;
        t.rdy = er; t.bcd = eb; t.own = eo; t.busy = ebusy;
        tbl.push_back(t);
    endfunction

    // Drive at the negedge, sample 1 time unit later, then move to next negedge.
    task automatic drive(input logic r, input logic [1:0] v, input logic [15:0] b0, input logic [15:0] b1);
        rst = r; vld = v; bcd_in = {b1, b0};
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 2'b00, 16'h0, 16'h0);
        @(negedge clk);
        drive(1'b1, 2'b00, 16'h0, 16'h0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; vld = '0; bcd_in = '0;
        rst1 = 1'b1; vld1 = '0; bcd_in1 = '0;

        // ---- Vector table -------------------------------------------------
        // Single request from req0, full 12-cycle dwell, then hold
        add(0, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'h0000, 2'b00, 0);
        add(0, 2'b01, 16'h1234, 16'h0000, 2'b01, 16'h0000, 2'b00, 0);
        for (int i = 0; i < 12; i++) add(0, 2'b00, 16'h0, 16'h0, 2'b00, 16'h1234, 2'b01, 1);
        for (int i = 0; i < 3; i++)  add(0, 2'b00, 16'h0, 16'h0, 2'b00, 16'h1234, 2'b00, 0);
        // Reset with both valid: ready must stay low; then both-valid round robin
        add(1, 2'b11, 16'h1111, 16'h2222, 2'b00, 16'h1234, 2'b00, 0);
        add(0, 2'b11, 16'h1111, 16'h2222, 2'b01, 16'h0000, 2'b00, 0);
        for (int i = 0; i < 12; i++) add(0, 2'b11, 16'h1111, 16'h2222, 2'b00, 16'h1111, 2'b01, 1);
        add(0, 2'b11, 16'h1111, 16'h2222, 2'b10, 16'h1111, 2'b00, 0);
        for (int i = 0; i < 12; i++) add(0, 2'b11, 16'h1111, 16'h2222, 2'b00, 16'h2222, 2'b10, 1);
        add(0, 2'b11, 16'h1111, 16'h2222, 2'b01, 16'h2222, 2'b00, 0);
        for (int i = 0; i < 12; i++) add(0, 2'b11, 16'h1111, 16'h2222, 2'b00, 16'h1111, 2'b01, 1);
        add(0, 2'b11, 16'h1111, 16'h2222, 2'b10, 16'h1111, 2'b00, 0);

        @(negedge clk);
        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].b0, tbl[i].b1);
            check($sformatf("vec%0d_ready", i), {30'd0, rdy},  {30'd0, tbl[i].rdy});
            check($sformatf("vec%0d_bcd",   i), {16'd0, obcd}, {16'd0, tbl[i].bcd});
            check($sformatf("vec%0d_owner", i), {30'd0, own},  {30'd0, tbl[i].own});
            check($sformatf("vec%0d_busy",  i), {31'd0, busy}, {31'd0, tbl[i].busy});
            @(negedge clk);
        end

        // ---- Req1 arrives during req0 dwell --------------------------------
        do_reset();
        drive(0, 2'b01, 16'hAAAA, 16'h0000);
        check("late_r0_ready", {30'd0, rdy}, 32'd1);
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            drive(0, 2'b10, 16'h0000, 16'hBBBB);
            check($sformatf("late_show%0d_ready", k), {30'd0, rdy}, 32'd0);
            check($sformatf("late_show%0d_busy", k), {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        drive(0, 2'b10, 16'h0000, 16'hBBBB);
        check("late_idle_ready", {30'd0, rdy}, 32'd2);
        check("late_idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        drive(0, 2'b00, 16'h0000, 16'h0000);
        check("late_r1_bcd", {16'd0, obcd}, 32'h0000BBBB);
        check("late_r1_owner", {30'd0, own}, 32'd2);

        // ---- Reset in the middle of a dwell --------------------------------
        @(negedge clk);
        do_reset();
        drive(0, 2'b01, 16'h5555, 16'h0000);
        check("abort_first_ready", {30'd0, rdy}, 32'd1);
        @(negedge clk);
        for (int k = 1; k < 5; k++) begin
            drive(0, 2'b11, 16'h6666, 16'h7777);
            check($sformatf("abort_show%0d_bcd", k), {16'd0, obcd}, 32'h00005555);
            @(negedge clk);
        end
        drive(1, 2'b11, 16'h6666, 16'h7777);
        check("abort_rst_ready", {30'd0, rdy}, 32'd0);
        check("abort_rst_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk);
        drive(0, 2'b11, 16'h6666, 16'h7777);
        check("abort_after_bcd", {16'd0, obcd}, 32'd0);
        check("abort_after_owner", {30'd0, own}, 32'd0);
        check("abort_after_busy", {31'd0, busy}, 32'd0);
        check("abort_after_ready", {30'd0, rdy}, 32'd1);
        @(negedge clk);
        drive(0, 2'b00, 16'h0000, 16'h0000);
        check("abort_regrant_bcd", {16'd0, obcd}, 32'h00006666);
        check("abort_regrant_owner", {30'd0, own}, 32'd1);
        @(negedge clk);

        // ---- CLK_DIV=1, DWELL_MS=1: 1-cycle dwell, grant every 2 cycles ----
        rst1 = 1'b1; vld1 = 2'b00;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            logic [1:0]  er;
            logic [1:0]  eo;
            logic [15:0] eb;
            rst1 = 1'b0; vld1 = 2'b11; bcd_in1 = {16'hD0D0, 16'h0C0C};
            #1;
            er = (k % 2 == 0) ? ((k % 4 == 0) ? 2'b01 : 2'b10) : 2'b00;
            eo = (k % 2 == 1) ? ((k % 4 == 1) ? 2'b01 : 2'b10) : 2'b00;
            eb = (k == 0) ? 16'h0000 : ((((k - 1) / 2) % 2 == 0) ? 16'h0C0C : 16'hD0D0);
            check($sformatf("fast%0d_ready", k), {30'd0, rdy1},  {30'd0, er});
            check($sformatf("fast%0d_owner", k), {30'd0, own1},  {30'd0, eo});
            check($sformatf("fast%0d_busy",  k), {31'd0, busy1}, {31'd0, (k % 2 == 1)});
            check($sformatf("fast%0d_bcd",   k), {16'd0, obcd1}, {16'd0, eb});
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
